// File: rtl/light_sequence_monitor.sv
// Watches the main/minor lamp buses of a two-road signal and latches the first
// sequencing or timing fault, driving flashing red until acknowledged.
module light_sequence_monitor #(
  parameter int MIN_MAIN_GREEN  = 50,
  parameter int MIN_MINOR_GREEN = 30,
  parameter int MAX_MINOR_GREEN = 30,
  parameter int YELLOW_TIME     = 10,
  parameter int FLASH_HALF      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] main_lights,
  input  logic [2:0] minor_lights,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red,
  output logic [7:0] phase_cycles,
  output logic [1:0] dbg_state
);

  // Handshake: none; every input is a level sampled on each rising clk edge.
  typedef enum logic [1:0] {ST_MONITOR = 2'd0, ST_FAULT = 2'd1, ST_RESYNC = 2'd2} state_t;
  typedef enum logic [1:0] {PH_MG = 2'd0, PH_MY = 2'd1, PH_NG = 2'd2, PH_NY = 2'd3} phase_t;

  localparam logic [7:0] L_MIN_MAIN  = 8'(MIN_MAIN_GREEN);
  localparam logic [7:0] L_MIN_MINOR = 8'(MIN_MINOR_GREEN);
  localparam logic [7:0] L_MAX_MINOR = 8'(MAX_MINOR_GREEN);
  localparam logic [7:0] L_YELLOW    = 8'(YELLOW_TIME);
  localparam logic [7:0] L_FLASH_END = 8'(FLASH_HALF - 1);

  state_t      r_state,      w_state_nxt;
  phase_t      r_phase_q,    w_phase_q_nxt;
  logic [7:0]  r_dwell,      w_dwell_nxt;
  logic        r_fault,      w_fault_nxt;
  logic [2:0]  r_fault_code, w_fault_code_nxt;
  logic        r_flash,      w_flash_nxt;
  logic [7:0]  r_flash_cnt,  w_flash_cnt_nxt;

  logic        w_conflict;
  logic        w_legal;
  phase_t      w_phase;
  phase_t      w_next_ph;
  logic [7:0]  w_min_dwell;
  logic [2:0]  w_mon_code;

  assign w_conflict = (main_lights != 3'b100) && (minor_lights != 3'b100);
  assign w_next_ph  = phase_t'(r_phase_q + 2'd1);

  always_comb begin
    w_legal = 1'b1;
    w_phase = PH_MG;
    case ({main_lights, minor_lights})
      6'b001_100: w_phase = PH_MG;
      6'b010_100: w_phase = PH_MY;
      6'b100_001: w_phase = PH_NG;
      6'b100_010: w_phase = PH_NY;
      default:    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_min_dwell = L_YELLOW;
    case (r_phase_q)
      PH_MG:   w_min_dwell = L_MIN_MAIN;
      PH_NG:   w_min_dwell = L_MIN_MINOR;
      default: w_min_dwell = L_YELLOW;
    endcase
  end

  // Nested ifs encode the cause priority conflict > illegal > order > short > overrun.
  always_comb begin
    w_mon_code = 3'd0;
    if (w_conflict)                    w_mon_code = 3'd2;
    else if (!w_legal)                 w_mon_code = 3'd1;
    else if (w_phase != r_phase_q) begin
      if (w_phase != w_next_ph)        w_mon_code = 3'd3;
      else if (r_dwell < w_min_dwell)  w_mon_code = 3'd4;
    end else begin
      if (((w_phase == PH_MY) || (w_phase == PH_NY)) && (r_dwell >= L_YELLOW))
        w_mon_code = 3'd5;
      else if ((w_phase == PH_NG) && (r_dwell >= L_MAX_MINOR))
        w_mon_code = 3'd5;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_q_nxt    = r_phase_q;
    w_dwell_nxt      = r_dwell;
    w_fault_nxt      = r_fault;
    w_fault_code_nxt = r_fault_code;
    w_flash_nxt      = r_flash;
    w_flash_cnt_nxt  = r_flash_cnt;
    case (r_state)
      ST_MONITOR: begin
        if (w_mon_code != 3'd0) begin
          w_state_nxt      = ST_FAULT;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = w_mon_code;
          w_flash_nxt      = 1'b1;
          w_flash_cnt_nxt  = 8'd0;
        end else if (w_phase == r_phase_q) begin
          w_dwell_nxt = (r_dwell == 8'hFF) ? 8'hFF : r_dwell + 8'd1;
        end else begin
          w_phase_q_nxt = w_phase;
          w_dwell_nxt   = 8'd1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_state_nxt      = ST_RESYNC;
          w_fault_nxt      = 1'b0;
          w_fault_code_nxt = 3'd0;
          w_flash_nxt      = 1'b0;
          w_flash_cnt_nxt  = 8'd0;
          w_dwell_nxt      = 8'd0;
        end else if (r_flash_cnt == L_FLASH_END) begin
          w_flash_nxt     = ~r_flash;
          w_flash_cnt_nxt = 8'd0;
        end else begin
          w_flash_cnt_nxt = r_flash_cnt + 8'd1;
        end
      end
      ST_RESYNC: begin
        w_dwell_nxt = 8'd0;
        if (w_conflict) begin
          w_state_nxt      = ST_FAULT;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = 3'd2;
          w_flash_nxt      = 1'b1;
          w_flash_cnt_nxt  = 8'd0;
        end else if (w_legal && (w_phase == PH_MG)) begin
          w_state_nxt   = ST_MONITOR;
          w_phase_q_nxt = PH_MG;
          w_dwell_nxt   = 8'd1;
        end
      end
      default: w_state_nxt = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_MONITOR;
      r_phase_q    <= PH_MG;
      r_dwell      <= 8'd0;
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
      r_flash      <= 1'b0;
      r_flash_cnt  <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase_q    <= w_phase_q_nxt;
      r_dwell      <= w_dwell_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
      r_flash      <= w_flash_nxt;
      r_flash_cnt  <= w_flash_cnt_nxt;
    end
  end

  assign fault        = r_fault;
  assign fault_code   = r_fault_code;
  assign flash_red    = r_flash;
  assign phase_cycles = r_dwell;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Bench for light_sequence_monitor: directed scenarios plus random lamp
// sequences, every cycle compared against a rule-level reference model.
module tb_light_sequence_monitor;

  localparam int MIN_MG = 50, MIN_NG = 30, MAX_NG = 30, YEL = 10, FH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] main_lights = 3'b001;
  logic [2:0] minor_lights = 3'b100;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_red;
  logic [7:0] phase_cycles;
  logic [1:0] dbg_state;

  light_sequence_monitor #(
    .MIN_MAIN_GREEN(MIN_MG), .MIN_MINOR_GREEN(MIN_NG), .MAX_MINOR_GREEN(MAX_NG),
    .YELLOW_TIME(YEL), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .main_lights(main_lights), .minor_lights(minor_lights),
    .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code), .flash_red(flash_red),
    .phase_cycles(phase_cycles), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // phase index 0..3 = MG, MY, NG, NY
  logic [2:0] drv_main  [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] drv_minor [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
  int         min_dw    [4] = '{MIN_MG, YEL, MIN_NG, YEL};

  // reference model: mode 0=monitor 1=fault 2=resync
  int m_mode, m_phase, m_dwell, m_code, m_fk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_dwell = 0; m_code = 0; m_fk = 0;
  endtask

  task automatic model_step(input logic [2:0] m, input logic [2:0] n, input logic c);
    bit conflict;
    int ph, code;
    conflict = (m != 3'b100) && (n != 3'b100);
    ph = -1;
    for (int i = 0; i < 4; i++)
      if (m == drv_main[i] && n == drv_minor[i]) ph = i;
    case (m_mode)
      0: begin
        code = 0;
        if (conflict) code = 2;
        else if (ph < 0) code = 1;
        else if (ph != m_phase) begin
          if (ph != (m_phase + 1) % 4) code = 3;
          else if (m_dwell < min_dw[m_phase]) code = 4;
        end else if (((ph == 1 || ph == 3) && m_dwell >= YEL) || (ph == 2 && m_dwell >= MAX_NG))
          code = 5;
        if (code != 0) begin
          m_mode = 1; m_code = code; m_fk = 0;
        end else if (ph == m_phase) begin
          m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
        end else begin
          m_phase = ph; m_dwell = 1;
        end
      end
      1: begin
        if (c) begin m_mode = 2; m_code = 0; m_dwell = 0; end
        else m_fk++;
      end
      default: begin
        m_dwell = 0;
        if (conflict) begin m_mode = 1; m_code = 2; m_fk = 0; end
        else if (ph == 0) begin m_mode = 0; m_phase = 0; m_dwell = 1; end
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    bit exp_flash;
    exp_flash = (m_mode == 1) && (((m_fk / FH) % 2) == 0);
    check_eq({tag, ".fault"}, 32'(fault), 32'(m_mode == 1));
    check_eq({tag, ".code"}, 32'(fault_code), 32'(m_code));
    check_eq({tag, ".flash"}, 32'(flash_red), 32'(exp_flash));
    check_eq({tag, ".state"}, 32'(dbg_state), 32'(m_mode));
    if (m_mode != 1) check_eq({tag, ".cycles"}, 32'(phase_cycles), 32'(m_dwell));
  endtask

  // driver: apply one sample, clock it, check #1 after the edge
  task automatic do_cycle(input logic [2:0] m, input logic [2:0] n, input logic c);
    main_lights = m; minor_lights = n; fault_clr = c;
    @(posedge clk);
    model_step(m, n, c);
    #1;
    check_outputs("cyc");
    fault_clr = 1'b0;
  endtask

  task automatic hold(input int ph, input int cnt, input bit rnd_clr);
    for (int i = 0; i < cnt; i++)
      do_cycle(drv_main[ph], drv_minor[ph], rnd_clr && ($urandom_range(0, 7) == 0));
  endtask

  task automatic legal_cycle();
    hold(0, MIN_MG, 0); check_eq("mg_dwell", 32'(phase_cycles), 32'd50);
    hold(1, YEL, 0);    check_eq("my_dwell", 32'(phase_cycles), 32'd10);
    hold(2, MIN_NG, 0); check_eq("ng_dwell", 32'(phase_cycles), 32'd30);
    hold(3, YEL, 0);    check_eq("ny_dwell", 32'(phase_cycles), 32'd10);
  endtask

  task automatic clear_to_mg();
    do_cycle(drv_main[0], drv_minor[0], 1'b1);
    do_cycle(drv_main[0], drv_minor[0], 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cur;
    model_reset();
    #2;
    apply_reset();

    // two fault-free legal cycles
    legal_cycle();
    legal_cycle();
    check_eq("legal_nofault", 32'(fault), 32'd0);

    // conflict, then watch flash pattern
    do_cycle(3'b001, 3'b001, 1'b0);
    check_eq("conflict_code", 32'(fault_code), 32'd2);
    hold(0, 3 * FH, 0);

    // clear on MY, resync through MY/NG/NY, then MG
    do_cycle(drv_main[1], drv_minor[1], 1'b1);
    check_eq("clr_state", 32'(dbg_state), 32'd2);
    hold(1, 15, 0); hold(2, 40, 0); hold(3, 15, 0);
    check_eq("resync_nofault", 32'(fault), 32'd0);
    do_cycle(drv_main[0], drv_minor[0], 1'b0);
    check_eq("resync_mg_cycles", 32'(phase_cycles), 32'd1);
    check_eq("resync_mg_state", 32'(dbg_state), 32'd0);

    // short yellow
    hold(0, MIN_MG, 0); hold(1, YEL - 1, 0); hold(2, 1, 0);
    check_eq("short_code", 32'(fault_code), 32'd4);
    do_cycle(3'b001, 3'b001, 1'b0);
    check_eq("first_fault_kept", 32'(fault_code), 32'd4);
    clear_to_mg();

    // illegal transition MG -> NG
    hold(0, MIN_MG, 0); hold(2, 1, 0);
    check_eq("order_code", 32'(fault_code), 32'd3);
    clear_to_mg();

    // yellow overrun on 11th sample
    hold(0, MIN_MG, 0); hold(1, YEL + 1, 0);
    check_eq("my_overrun", 32'(fault_code), 32'd5);
    clear_to_mg();

    // minor-green overrun on 31st sample
    hold(0, MIN_MG, 0); hold(1, YEL, 0); hold(2, MAX_NG + 1, 0);
    check_eq("ng_overrun", 32'(fault_code), 32'd5);

    // conflict while resyncing
    do_cycle(drv_main[1], drv_minor[1], 1'b1);
    do_cycle(3'b010, 3'b010, 1'b0);
    check_eq("resync_conflict", 32'(fault_code), 32'd2);
    clear_to_mg();

    // illegal pair, then async reset mid-fault
    do_cycle(3'b110, 3'b100, 1'b0);
    check_eq("illegal_code", 32'(fault_code), 32'd1);
    hold(0, 3, 0);
    #2;
    apply_reset();
    legal_cycle();
    check_eq("post_reset_nofault", 32'(fault), 32'd0);

    // random sequences around the dwell limits
    cur = 0;
    for (int s = 0; s < 70; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++)
          do_cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
      end else begin
        cur = (r == 1) ? $urandom_range(0, 3) : (cur + 1) % 4;
        case (cur)
          0:       hold(0, $urandom_range(MIN_MG - 2, MIN_MG + 6), 1);
          2:       hold(2, $urandom_range(MIN_NG - 2, MAX_NG + 2), 1);
          default: hold(cur, $urandom_range(YEL - 2, YEL + 2), 1);
        endcase
      end
      if (m_mode == 1) begin
        hold(cur, $urandom_range(1, 20), 0);
        clear_to_mg();
        cur = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
